mem_arbiter: RTL and testbench

//  Two-port arbiter sharing the single-port data memory between port A (CPU) and port B
//  (UART program loader / debug DMA). One memory access per cycle, round-robin on contention,

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_hold_counter.sv | 44 ++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: owner encodings, port ids and
// a helper that sizes the hold counter from MAX_HOLD.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Bits needed to hold 0..max_hold inclusive.
    function automatic int hold_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the memory arbiter; the requester uses master,
// the arbiter uses slave.
interface mem_arbiter_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16
);
    logic                 req;
    logic                 we;
    logic                 lock;
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
    logic                 gnt;
    logic                 rvalid;
    logic [WORD_SIZE-1:0] rdata;

    modport master (
        output req,
        output we,
        output lock,
        output addr,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  lock,
        input  addr,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/mem_arbiter_hold_counter.sv
// Saturating count of consecutive grants to the current owner; bounds how
// long a locked owner can keep the memory while the other port waits.
module arb_hold_counter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    input  logic load_one,
    output logic saturated
);

    localparam int CW = hold_width(MAX_HOLD);
    localparam logic [CW-1:0] MAX_W = CW'(MAX_HOLD);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // clr wins over load_one, which wins over inc; inc stops at MAX_HOLD.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load_one) begin
            count_d = CW'(1);
        end else if (inc && (count_q < MAX_W)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign saturated = (count_q >= MAX_W);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port data memory: one access per cycle,
// round-robin on contention, optional lock bounded by MAX_HOLD.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16,
    parameter int MAX_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_arbiter_if.slave         a_port,
    mem_arbiter_if.slave         b_port,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_we,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    owner_e owner_q;
    owner_e owner_d;
    port_e  last_gnt_q;
    port_e  last_gnt_d;

    logic a_gnt;
    logic b_gnt;
    logic hold_inc;
    logic hold_clr;
    logic hold_load;
    logic hold_sat;

    logic a_rvalid_q;
    logic a_rvalid_d;
    logic b_rvalid_q;
    logic b_rvalid_d;

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_counter (
        .clk       (clk),
        .reset     (reset),
        .inc       (hold_inc),
        .clr       (hold_clr),
        .load_one  (hold_load),
        .saturated (hold_sat)
    );

    // A locked owner keeps priority only until the hold counter saturates.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
            case ({a_port.req, b_port.req})
                2'b10: a_gnt = 1'b1;
                2'b01: b_gnt = 1'b1;
                2'b11: begin
                    if ((owner_q == OWN_A) && a_port.lock && !hold_sat) begin
                        a_gnt = 1'b1;
                    end else if ((owner_q == OWN_B) && b_port.lock && !hold_sat) begin
                        b_gnt = 1'b1;
                    end else if (last_gnt_q == PORT_B) begin
                        a_gnt = 1'b1;
                    end else begin
                        b_gnt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        hold_inc   = 1'b0;
        hold_clr   = 1'b0;
        hold_load  = 1'b0;
        if (a_gnt) begin
            owner_d    = OWN_A;
            last_gnt_d = PORT_A;
            hold_inc   = (owner_q == OWN_A);
            hold_load  = (owner_q != OWN_A);
        end else if (b_gnt) begin
            owner_d    = OWN_B;
            last_gnt_d = PORT_B;
            hold_inc   = (owner_q == OWN_B);
            hold_load  = (owner_q != OWN_B);
        end else begin
            owner_d  = OWN_IDLE;
            hold_clr = 1'b1;
        end
    end

    // last_gnt resets to B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OWN_IDLE;
            last_gnt_q <= PORT_B;
        end else begin
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (a_gnt) begin
            mem_addr  = a_port.addr;
            mem_wdata = a_port.wdata;
            mem_we    = a_port.we;
        end else if (b_gnt) begin
            mem_addr  = b_port.addr;
            mem_wdata = b_port.wdata;
            mem_we    = b_port.we;
        end
    end

    always_comb begin
        a_rvalid_d = a_gnt & ~a_port.we;
        b_rvalid_d = b_gnt & ~b_port.we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // Gating with reset drops a read that was granted just before reset rose.
    assign a_port.gnt    = a_gnt;
    assign b_port.gnt    = b_gnt;
    assign a_port.rvalid = a_rvalid_q & ~reset;
    assign b_port.rvalid = b_rvalid_q & ~reset;
    assign a_port.rdata  = mem_rdata;
    assign b_port.rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a write-first
// synchronous memory model behind it.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [15:0] mem [0:65535];

    int total;
    int bad;

    mem_arbiter_if #(.WORD_SIZE(16), .ADDR_SIZE(16)) a_if ();
    mem_arbiter_if #(.WORD_SIZE(16), .ADDR_SIZE(16)) b_if ();

    mem_arbiter #(
        .WORD_SIZE (16),
        .ADDR_SIZE (16),
        .MAX_HOLD  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_port    (a_if.slave),
        .b_port    (b_if.slave),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic lock,
                           input logic [15:0] addr, input logic [15:0] wdata);
        a_if.req = req; a_if.we = we; a_if.lock = lock;
        a_if.addr = addr; a_if.wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic lock,
                           input logic [15:0] addr, input logic [15:0] wdata);
        b_if.req = req; b_if.we = we; b_if.lock = lock;
        b_if.addr = addr; b_if.wdata = wdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_a(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_b(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        drive_a(1'b1, 1'b1, 1'b0, 16'h0005, 16'h1111);
        drive_b(1'b1, 1'b1, 1'b0, 16'h0006, 16'h2222);
        #3;
        total++;
        if ({a_if.gnt, b_if.gnt} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_gnt got=%b exp=00", {a_if.gnt, b_if.gnt});
        end
        total++;
        if (mem_we !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_mem_we got=%b exp=0", mem_we);
        end
        total++;
        if ({a_if.rvalid, b_if.rvalid} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_rvalid got=%b exp=00", {a_if.rvalid, b_if.rvalid});
        end
        next_cycle();
        reset = 1'b0;
        drive_a(1'b0, 1'b0, 1'b0, 16'h0005, 16'h1111);
        drive_b(1'b0, 1'b0, 1'b0, 16'h0006, 16'h2222);
        #3;
        total++;
        if ({a_if.gnt, b_if.gnt, mem_we} !== 3'b000 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            bad++;
            $display("[TB] FAIL idle_bus got gnt=%b%b we=%b addr=%h wdata=%h exp all zero",
                     a_if.gnt, b_if.gnt, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        drive_a(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        #3;
        total++;
        if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b0) begin
            bad++; $display("[TB] FAIL single_gnt got=%b%b exp=10", a_if.gnt, b_if.gnt);
        end
        total++;
        if (mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
            bad++; $display("[TB] FAIL single_bus got addr=%h we=%b exp addr=0010 we=0", mem_addr, mem_we);
        end
        next_cycle();
        drive_a(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #3;
        total++;
        if (a_if.rvalid !== 1'b1 || b_if.rvalid !== 1'b0) begin
            bad++; $display("[TB] FAIL single_rvalid got=%b%b exp=10", a_if.rvalid, b_if.rvalid);
        end
        total++;
        if (a_if.rdata !== 16'h1234) begin
            bad++; $display("[TB] FAIL single_rdata got=%h exp=1234", a_if.rdata);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic exp_a;
        logic prev_a;
        do_reset();
        drive_a(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
        drive_b(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
        prev_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #3;
            exp_a = (i % 2 == 0);
            total++;
            if (a_if.gnt !== exp_a || b_if.gnt !== ~exp_a) begin
                bad++; $display("[TB] FAIL rr_gnt[%0d] got=%b%b exp=%b%b", i, a_if.gnt, b_if.gnt, exp_a, ~exp_a);
            end
            total++;
            if (mem_addr !== (exp_a ? 16'h0020 : 16'h0030)) begin
                bad++; $display("[TB] FAIL rr_addr[%0d] got=%h exp=%h", i, mem_addr, exp_a ? 16'h0020 : 16'h0030);
            end
            if (i > 0) begin
                total++;
                if (a_if.rvalid !== prev_a || b_if.rvalid !== ~prev_a ||
                    a_if.rdata !== (prev_a ? 16'h00AA : 16'h00BB)) begin
                    bad++;
                    $display("[TB] FAIL rr_read[%0d] got rvalid=%b%b rdata=%h exp rvalid=%b%b rdata=%h",
                             i, a_if.rvalid, b_if.rvalid, a_if.rdata, prev_a, ~prev_a,
                             prev_a ? 16'h00AA : 16'h00BB);
                end
            end
            prev_a = exp_a;
            next_cycle();
        end
        drive_a(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_b(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        next_cycle();
    endtask

    task automatic test_lock_hold();
        logic exp_b;
        int   wait_cnt;
        int   max_wait;
        do_reset();
        drive_b(1'b1, 1'b1, 1'b1, 16'h0200, 16'h5555);
        #3;
        total++;
        if (b_if.gnt !== 1'b1 || a_if.gnt !== 1'b0) begin
            bad++; $display("[TB] FAIL lock_first got=%b%b exp=01", a_if.gnt, b_if.gnt);
        end
        next_cycle();
        drive_a(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0);
        wait_cnt = 0;
        max_wait = 0;
        for (int i = 1; i < 19; i++) begin
            #3;
            exp_b = (i % 9 != 8);
            total++;
            if (b_if.gnt !== exp_b || a_if.gnt !== ~exp_b) begin
                bad++; $display("[TB] FAIL lock_seq[%0d] got=%b%b exp=%b%b", i, a_if.gnt, b_if.gnt, ~exp_b, exp_b);
            end
            if (a_if.gnt === 1'b1) wait_cnt = 0;
            else wait_cnt++;
            if (wait_cnt > max_wait) max_wait = wait_cnt;
            next_cycle();
        end
        total++;
        if (max_wait != 8) begin
            bad++; $display("[TB] FAIL lock_max_wait got=%0d exp=8", max_wait);
        end
        drive_a(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_b(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        next_cycle();
    endtask

    task automatic test_write_then_read();
        do_reset();
        drive_a(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
        #3;
        total++;
        if (a_if.gnt !== 1'b1) begin
            bad++; $display("[TB] FAIL wr_setup got=%b exp=1", a_if.gnt);
        end
        next_cycle();
        drive_a(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0);
        drive_b(1'b1, 1'b1, 1'b0, 16'h0100, 16'hBEEF);
        #3;
        total++;
        if (a_if.gnt !== 1'b0 || b_if.gnt !== 1'b1) begin
            bad++; $display("[TB] FAIL wr_b_gnt got=%b%b exp=01", a_if.gnt, b_if.gnt);
        end
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 16'hBEEF) begin
            bad++;
            $display("[TB] FAIL wr_bus got we=%b addr=%h wdata=%h exp we=1 addr=0100 wdata=beef",
                     mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        drive_b(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #3;
        total++;
        if (a_if.gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0100) begin
            bad++;
            $display("[TB] FAIL wr_a_gnt got gnt=%b we=%b addr=%h exp gnt=1 we=0 addr=0100",
                     a_if.gnt, mem_we, mem_addr);
        end
        total++;
        if (b_if.rvalid !== 1'b0) begin
            bad++; $display("[TB] FAIL wr_no_rvalid got=%b exp=0", b_if.rvalid);
        end
        next_cycle();
        drive_a(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #3;
        total++;
        if (a_if.rvalid !== 1'b1 || a_if.rdata !== 16'hBEEF) begin
            bad++; $display("[TB] FAIL wr_readback got rvalid=%b rdata=%h exp rvalid=1 rdata=beef",
                            a_if.rvalid, a_if.rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        drive_a(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        #3;
        total++;
        if (a_if.gnt !== 1'b1) begin
            bad++; $display("[TB] FAIL rmid_pre got=%b exp=1", a_if.gnt);
        end
        next_cycle();
        reset = 1'b1;
        drive_b(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
        for (int i = 0; i < 2; i++) begin
            #3;
            total++;
            if ({a_if.rvalid, a_if.gnt, b_if.gnt, mem_we} !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL rmid_hold[%0d] got rvalid=%b gnt=%b%b we=%b exp all 0",
                         i, a_if.rvalid, a_if.gnt, b_if.gnt, mem_we);
            end
            next_cycle();
        end
        reset = 1'b0;
        #3;
        total++;
        if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b0 || a_if.rvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmid_tie got gnt=%b%b rvalid=%b exp gnt=10 rvalid=0",
                     a_if.gnt, b_if.gnt, a_if.rvalid);
        end
        next_cycle();
    endtask

    task automatic test_lock_idle();
        drive_a(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0);
        drive_b(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 20; i++) begin
            #3;
            total++;
            if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b0) begin
                bad++; $display("[TB] FAIL lidle_gnt[%0d] got=%b%b exp=10", i, a_if.gnt, b_if.gnt);
            end
            next_cycle();
        end
        drive_b(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
        #3;
        total++;
        if (b_if.gnt !== 1'b1 || a_if.gnt !== 1'b0) begin
            bad++; $display("[TB] FAIL lidle_b_in got=%b%b exp=01", a_if.gnt, b_if.gnt);
        end
        next_cycle();
        #3;
        total++;
        if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b0) begin
            bad++; $display("[TB] FAIL lidle_a_back got=%b%b exp=10", a_if.gnt, b_if.gnt);
        end
        next_cycle();
        drive_a(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_b(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        next_cycle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0010] = 16'h1234;
        mem[16'h0020] = 16'h00AA;
        mem[16'h0030] = 16'h00BB;
        reset = 1'b1;
        drive_a(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_b(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_hold();
        test_write_then_read();
        test_reset_mid();
        test_lock_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
